ife_result_collector: RTL and testbench

//  Core-side end of the IFE parallel path. Accepts a parallel dispatch (core mask + block id), and tracks
//  per-core completion. Captures each core's register writes into a shadow register file.

---
 rtl/ife_result_collector_pkg.sv | 21 ++
 rtl/ife_result_collector_if.sv | 37 +++
 rtl/ife_result_collector_core_shadow.sv | 45 ++++
 rtl/ife_result_collector.sv | 129 ++++++++++++
 tb/tb_ife_result_collector.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ife_result_collector_pkg.sv
// Shared types and constants for the IFE result collector and its per-core shadows.
package ife_pkg;

    localparam int IFE_REG_ADDR_W = 5;
    localparam int IFE_BLOCK_ID_W = 8;

    typedef logic [IFE_BLOCK_ID_W-1:0] ife_block_id_t;

    typedef enum logic [1:0] {
        IFE_RC_IDLE,
        IFE_RC_COLLECT,
        IFE_RC_COMMIT,
        IFE_RC_ABORT
    } ife_rc_state_e;

    // One spare bit so the counter can saturate above TIMEOUT_CYCLES-1.
    function automatic int ife_cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/ife_result_collector_if.sv
// Dispatch, core write-back and commit signals between the IFE cores and the collector.
interface ife_result_collector_if
    import ife_pkg::*;
#(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_CORES      = 3,
    parameter int NUM_REGS       = 32,
    parameter int REG_WIDTH      = 64
) ();

    logic [NUM_CORES-1:0]                                 dispatch_valid;
    logic [BLOCK_ID_WIDTH-1:0]                            dispatch_block_id;
    logic                                                 dispatch_ready;
    logic [NUM_CORES-1:0]                                 core_wr_en;
    logic [NUM_CORES-1:0][IFE_REG_ADDR_W-1:0]             core_wr_addr;
    logic [NUM_CORES-1:0][REG_WIDTH-1:0]                  core_wr_data;
    logic [NUM_CORES-1:0]                                 core_done;
    logic                                                 commit_valid;
    logic [BLOCK_ID_WIDTH-1:0]                            commit_block_id;
    logic [NUM_CORES-1:0][NUM_REGS-1:0][REG_WIDTH-1:0]    result_core;
    logic                                                 abort_serial;
    logic                                                 dispatch_drop;
    logic                                                 spurious_err;

    modport master (
        output dispatch_valid, dispatch_block_id, core_wr_en, core_wr_addr, core_wr_data, core_done,
        input  dispatch_ready, commit_valid, commit_block_id, result_core, abort_serial,
               dispatch_drop, spurious_err
    );

    modport slave (
        input  dispatch_valid, dispatch_block_id, core_wr_en, core_wr_addr, core_wr_data, core_done,
        output dispatch_ready, commit_valid, commit_block_id, result_core, abort_serial,
               dispatch_drop, spurious_err
    );

endinterface

// File: rtl/ife_result_collector_core_shadow.sv
// One core's shadow register image plus its end-of-block flag.
module ife_core_shadow
    import ife_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int REG_WIDTH = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                enable,
    input  logic                                wr_en,
    input  logic [IFE_REG_ADDR_W-1:0]           wr_addr,
    input  logic [REG_WIDTH-1:0]                wr_data,
    input  logic                                done_in,
    output logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs,
    output logic                                done
);

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] r_regs;
    logic                               r_done;

    // NOTE: this storage is reset on purpose: the image is an observable output that must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs <= '0;
            r_done <= 1'b0;
        end else if (clear) begin
            r_regs <= '0;
            r_done <= 1'b0;
        end else if (enable && !r_done) begin
            // Register 0 is hardwired to zero; a write sampled with done still lands.
            if (wr_en && (wr_addr != '0) && (int'(wr_addr) < NUM_REGS)) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (done_in) begin
                r_done <= 1'b1;
            end
        end
    end

    assign regs = r_regs;
    assign done = r_done;

endmodule

// File: rtl/ife_result_collector.sv
// Collects per-core completion and register write-back for one parallel block, then commits or aborts.
module ife_result_collector
    import ife_pkg::*;
#(
    parameter int BLOCK_ID_WIDTH = 8,
    parameter int NUM_CORES      = 3,
    parameter int NUM_REGS       = 32,
    parameter int REG_WIDTH      = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    ife_result_collector_if.slave  bus
);

    localparam int CNT_W = ife_cnt_width(TIMEOUT_CYCLES);

    ife_rc_state_e                                    r_state;
    ife_rc_state_e                                    w_state_next;
    logic [NUM_CORES-1:0]                             r_active_mask;
    logic [BLOCK_ID_WIDTH-1:0]                        r_block_id;
    logic [CNT_W-1:0]                                 r_timeout_cnt;
    logic                                             r_dispatch_drop;
    logic                                             r_spurious_err;
    logic [NUM_CORES-1:0]                             w_done_mask;
    logic [NUM_CORES-1:0]                             w_done_now;
    logic [NUM_CORES-1:0]                             w_core_evt;
    logic [NUM_CORES-1:0][NUM_REGS-1:0][REG_WIDTH-1:0] w_regs;
    logic                                             w_collect;
    logic                                             w_accept;
    logic                                             w_all_done;
    logic                                             w_timeout;
    logic                                             w_commit_valid;
    logic                                             w_abort_serial;
    logic                                             w_dispatch_ready;
    logic [BLOCK_ID_WIDTH-1:0]                        w_commit_block_id;

    assign w_collect  = (r_state == IFE_RC_COLLECT);
    assign w_accept   = (r_state == IFE_RC_IDLE) && (|bus.dispatch_valid);
    assign w_done_now = w_done_mask | (bus.core_done & r_active_mask);
    assign w_all_done = (w_done_now == r_active_mask);
    assign w_timeout  = (r_timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_core_evt = bus.core_done | bus.core_wr_en;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next      = r_state;
        w_commit_valid    = 1'b0;
        w_abort_serial    = 1'b0;
        w_dispatch_ready  = 1'b0;
        w_commit_block_id = '0;
        case (r_state)
            IFE_RC_IDLE: begin
                w_dispatch_ready = 1'b1;
                if (w_accept) w_state_next = IFE_RC_COLLECT;
            end
            IFE_RC_COLLECT: begin
                // Completion outranks a timeout landing in the same cycle.
                if (w_all_done)     w_state_next = IFE_RC_COMMIT;
                else if (w_timeout) w_state_next = IFE_RC_ABORT;
            end
            IFE_RC_COMMIT: begin
                w_commit_valid    = 1'b1;
                w_commit_block_id = r_block_id;
                w_state_next      = IFE_RC_IDLE;
            end
            IFE_RC_ABORT: begin
                w_abort_serial    = 1'b1;
                w_commit_block_id = r_block_id;
                w_state_next      = IFE_RC_IDLE;
            end
            default: w_state_next = IFE_RC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IFE_RC_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_mask   <= '0;
            r_block_id      <= '0;
            r_timeout_cnt   <= '0;
            r_dispatch_drop <= 1'b0;
            r_spurious_err  <= 1'b0;
        end else begin
            r_dispatch_drop <= (r_state != IFE_RC_IDLE) && (|bus.dispatch_valid);
            r_spurious_err  <= ((r_state == IFE_RC_IDLE) && (|w_core_evt)) ||
                               (w_collect && (|(w_core_evt & ~r_active_mask)));
            if (w_accept) begin
                r_active_mask <= bus.dispatch_valid;
                r_block_id    <= bus.dispatch_block_id;
                r_timeout_cnt <= '0;
            end else if (w_collect && !(&r_timeout_cnt)) begin
                r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        ife_core_shadow #(
            .NUM_REGS  (NUM_REGS),
            .REG_WIDTH (REG_WIDTH)
        ) u_shadow (
            .clk     (clk),
            .rst     (rst),
            .clear   (w_accept),
            .enable  (w_collect && r_active_mask[g]),
            .wr_en   (bus.core_wr_en[g]),
            .wr_addr (bus.core_wr_addr[g]),
            .wr_data (bus.core_wr_data[g]),
            .done_in (bus.core_done[g]),
            .regs    (w_regs[g]),
            .done    (w_done_mask[g])
        );
    end

    assign bus.dispatch_ready  = w_dispatch_ready;
    assign bus.commit_valid    = w_commit_valid;
    assign bus.abort_serial    = w_abort_serial;
    assign bus.commit_block_id = w_commit_block_id;
    assign bus.dispatch_drop   = r_dispatch_drop;
    assign bus.spurious_err    = r_spurious_err;
    assign bus.result_core     = w_regs;

endmodule

// File: tb/tb_ife_result_collector.sv
// Directed scenarios plus random traffic, checked cycle by cycle against a block-level reference model.
module tb_ife_result_collector;
    import ife_pkg::*;

    localparam int NC = 3;
    localparam int NR = 32;
    localparam int RW = 64;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    ife_result_collector_if #(.BLOCK_ID_WIDTH(8), .NUM_CORES(NC), .NUM_REGS(NR), .REG_WIDTH(RW)) bus ();

    ife_result_collector #(
        .BLOCK_ID_WIDTH (8),
        .NUM_CORES      (NC),
        .NUM_REGS       (NR),
        .REG_WIDTH      (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: block bookkeeping in plain variables, advanced once per clock edge.
    bit            m_in_block = 0;
    bit            m_commit_p = 0;
    bit            m_abort_p  = 0;
    bit            m_idle;
    logic [NC-1:0] m_mask = '0;
    logic [NC-1:0] m_done = '0;
    logic [NC-1:0] m_act;
    ife_block_id_t m_id = '0;
    int            m_age = 0;
    logic [RW-1:0] m_sh [NC][NR];
    bit            exp_ready = 1, exp_commit = 0, exp_abort = 0, exp_drop = 0, exp_spur = 0;
    ife_block_id_t exp_id = '0;

    task automatic model_clear_shadows();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) m_sh[c][r] = '0;
    endtask

    initial model_clear_shadows();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_block = 0; m_commit_p = 0; m_abort_p = 0;
            m_mask = '0; m_done = '0; m_id = '0; m_age = 0;
            model_clear_shadows();
            exp_ready = 1; exp_commit = 0; exp_abort = 0; exp_drop = 0; exp_spur = 0; exp_id = '0;
        end else begin
            m_idle   = !m_in_block && !m_commit_p && !m_abort_p;
            m_act    = bus.core_done | bus.core_wr_en;
            exp_drop = (bus.dispatch_valid != '0) && !m_idle;
            exp_spur = m_idle ? (m_act != '0) : (m_in_block ? ((m_act & ~m_mask) != '0) : 1'b0);
            if (m_commit_p || m_abort_p) begin
                m_commit_p = 0;
                m_abort_p  = 0;
            end else if (m_idle) begin
                if (bus.dispatch_valid != '0) begin
                    m_in_block = 1;
                    m_mask     = bus.dispatch_valid;
                    m_id       = bus.dispatch_block_id;
                    m_done     = '0;
                    m_age      = 0;
                    model_clear_shadows();
                end
            end else begin
                for (int c = 0; c < NC; c++) begin
                    if (m_mask[c] && !m_done[c]) begin
                        if (bus.core_wr_en[c] && bus.core_wr_addr[c] != 5'd0)
                            m_sh[c][bus.core_wr_addr[c]] = bus.core_wr_data[c];
                        if (bus.core_done[c]) m_done[c] = 1'b1;
                    end
                end
                if (m_done == m_mask) begin
                    m_in_block = 0; m_commit_p = 1;
                end else if (m_age == TO - 1) begin
                    m_in_block = 0; m_abort_p = 1;
                end else begin
                    m_age++;
                end
            end
            exp_commit = m_commit_p;
            exp_abort  = m_abort_p;
            exp_id     = (m_commit_p || m_abort_p) ? m_id : '0;
            exp_ready  = !m_in_block && !m_commit_p && !m_abort_p;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("ready",  64'(bus.dispatch_ready),  64'(exp_ready));
            check("commit", 64'(bus.commit_valid),    64'(exp_commit));
            check("abort",  64'(bus.abort_serial),    64'(exp_abort));
            check("drop",   64'(bus.dispatch_drop),   64'(exp_drop));
            check("spur",   64'(bus.spurious_err),    64'(exp_spur));
            check("id",     64'(bus.commit_block_id), 64'(exp_id));
            if (exp_commit || exp_abort) begin
                for (int c = 0; c < NC; c++)
                    for (int r = 0; r < NR; r++)
                        check($sformatf("res_c%0d_r%0d", c, r), bus.result_core[c][r], m_sh[c][r]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.dispatch_valid    = '0;
        bus.dispatch_block_id = '0;
        bus.core_wr_en        = '0;
        bus.core_wr_addr      = '0;
        bus.core_wr_data      = '0;
        bus.core_done         = '0;
    endtask

    // Present one cycle of inputs (same address for all cores), let the edge sample them, then idle the bus.
    task automatic drive(input logic [NC-1:0] dv, input logic [7:0] bid, input logic [NC-1:0] wr,
                         input logic [4:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [NC-1:0] done);
        bus.dispatch_valid    = dv;
        bus.dispatch_block_id = bid;
        bus.core_wr_en        = wr;
        for (int c = 0; c < NC; c++) bus.core_wr_addr[c] = addr;
        bus.core_wr_data[0]   = d0;
        bus.core_wr_data[1]   = d1;
        bus.core_wr_data[2]   = d2;
        bus.core_done         = done;
        tick();
        clear_in();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst = 1'b1;
        tick(); tick();
        check("rst_ready",  64'(bus.dispatch_ready), 64'd1);
        check("rst_commit", 64'(bus.commit_valid),   64'd0);
        check("rst_result", 64'(|bus.result_core),   64'd0);
        rst = 1'b0;
        chk_on = 1'b1;
        tick();

        // 1: all three cores, done at +3/+5/+4
        drive(3'b111, 8'h2A, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        check("t1_ready_low", 64'(bus.dispatch_ready), 64'd0);
        drive(3'b000, 8'h00, 3'b111, 5'd5, 64'h11, 64'h22, 64'h33, 3'b000);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b001);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b100);
        check("t1_no_early_commit", 64'(bus.commit_valid), 64'd0);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b010);
        check("t1_commit", 64'(bus.commit_valid),    64'd1);
        check("t1_id",     64'(bus.commit_block_id), 64'h2A);
        check("t1_c0_r5",  bus.result_core[0][5],    64'h11);
        check("t1_c1_r5",  bus.result_core[1][5],    64'h22);
        check("t1_c2_r5",  bus.result_core[2][5],    64'h33);
        tick();
        check("t1_commit_once", 64'(bus.commit_valid),   64'd0);
        check("t1_ready_back",  64'(bus.dispatch_ready), 64'd1);

        // 2: core 1 outside the mask
        drive(3'b101, 8'h55, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b010, 5'd3, 64'h0, 64'hAB, 64'h0, 3'b010);
        check("t2_spur", 64'(bus.spurious_err), 64'd1);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b001);
        check("t2_spur_once", 64'(bus.spurious_err), 64'd0);
        check("t2_wait",      64'(bus.commit_valid), 64'd0);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b100);
        check("t2_commit",  64'(bus.commit_valid),    64'd1);
        check("t2_id",      64'(bus.commit_block_id), 64'h55);
        check("t2_c1_zero", 64'(|bus.result_core[1]), 64'd0);
        tick();

        // 3: timeout with only core 0 done
        drive(3'b011, 8'h33, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b001);
        for (int k = 2; k < TO; k++) begin
            check("t3_no_abort_yet", 64'(bus.abort_serial), 64'd0);
            tick();
        end
        check("t3_no_abort_yet", 64'(bus.abort_serial), 64'd0);
        tick();
        check("t3_abort",     64'(bus.abort_serial),    64'd1);
        check("t3_no_commit", 64'(bus.commit_valid),    64'd0);
        check("t3_id",        64'(bus.commit_block_id), 64'h33);
        tick();
        check("t3_ready", 64'(bus.dispatch_ready), 64'd1);
        check("t3_abort_once", 64'(bus.abort_serial), 64'd0);

        // 4: dispatch during COLLECT is dropped
        drive(3'b111, 8'h44, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b111, 8'h07, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        check("t4_drop", 64'(bus.dispatch_drop), 64'd1);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b111);
        check("t4_drop_once", 64'(bus.dispatch_drop),   64'd0);
        check("t4_commit",    64'(bus.commit_valid),    64'd1);
        check("t4_id",        64'(bus.commit_block_id), 64'h44);
        tick();

        // 5: r0 stays zero; writes after done are ignored
        drive(3'b011, 8'h05, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b001, 5'd0, 64'hFFFF, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b001, 5'd7, 64'h77, 64'h0, 64'h0, 3'b001);
        drive(3'b000, 8'h00, 3'b001, 5'd7, 64'h99, 64'h0, 64'h0, 3'b000);
        check("t5_no_spur", 64'(bus.spurious_err), 64'd0);
        drive(3'b000, 8'h00, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b010);
        check("t5_commit", 64'(bus.commit_valid),  64'd1);
        check("t5_r0",     bus.result_core[0][0],  64'h0);
        check("t5_r7",     bus.result_core[0][7],  64'h77);
        tick();

        // 6: reset in the middle of a block
        drive(3'b111, 8'h66, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b111, 5'd9, 64'h1, 64'h2, 64'h3, 3'b000);
        rst = 1'b1;
        #1;
        check("t6_ready",  64'(bus.dispatch_ready),  64'd1);
        check("t6_commit", 64'(bus.commit_valid),    64'd0);
        check("t6_abort",  64'(bus.abort_serial),    64'd0);
        check("t6_id",     64'(bus.commit_block_id), 64'd0);
        check("t6_result", 64'(|bus.result_core),    64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t6_no_pulse", 64'(bus.commit_valid | bus.abort_serial), 64'd0);
        drive(3'b100, 8'h77, 3'b000, 5'd0, 64'h0, 64'h0, 64'h0, 3'b000);
        drive(3'b000, 8'h00, 3'b100, 5'd4, 64'h0, 64'h0, 64'hBEEF, 3'b100);
        check("t6_commit_after", 64'(bus.commit_valid),    64'd1);
        check("t6_id_after",     64'(bus.commit_block_id), 64'h77);
        check("t6_r4_after",     bus.result_core[2][4],    64'hBEEF);
        tick();

        // Random traffic; the per-cycle monitor compares against the model.
        for (int n = 0; n < 4000; n++) begin
            bus.dispatch_valid    = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            bus.dispatch_block_id = 8'($urandom);
            bus.core_wr_en        = 3'($urandom) & 3'($urandom);
            bus.core_done         = 3'($urandom) & 3'($urandom) & 3'($urandom);
            for (int c = 0; c < NC; c++) begin
                bus.core_wr_addr[c] = 5'($urandom);
                bus.core_wr_data[c] = {$urandom, $urandom};
            end
            tick();
        end
        clear_in();
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
